// File: rtl/tick_sched.sv
// Run controller and round-robin time-slot scheduler driven by a programmable tick divider.
// Optional half-rate phase output, ticking on every other prescaler wrap: define TICK_SCHED_PHASE_EN.

module tick_sched #(
    parameter int NREQ  = 4,
    parameter int DIV_W = 8,
    parameter int CYC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [DIV_W-1:0] div,
    input  logic [CYC_W-1:0] cyc_limit,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic             tick,
    output logic [CYC_W-1:0] cyc_count,
    output logic             busy,
`ifdef TICK_SCHED_PHASE_EN
    output logic             done,
    output logic             phase
`else
    output logic             done
`endif
);

    // state  | meaning
    // S_IDLE | waiting for start; no run in progress
    // S_RUN  | prescaler running, ticks issued and granted
    // S_DONE | cyc_limit ticks issued; cyc_count holds the final value

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] pre, div_q;
    logic [CYC_W-1:0] lim_q;
    logic [PW-1:0]    ptr, ptr_nxt, gnt_idx, cand_idx;
    logic [NREQ-1:0]  gnt_oh;
    logic             gnt_found;
    logic             do_start, do_wrap, do_tick;
    logic             at_lim, wrap, tick_ok;

    assign at_lim = (cyc_count == lim_q);
    assign wrap   = (pre == div_q);

`ifdef TICK_SCHED_PHASE_EN
    assign tick_ok = ~phase;
`else
    assign tick_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        do_start  = 1'b0;
        do_wrap   = 1'b0;
        do_tick   = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    do_start  = 1'b1;
                    state_nxt = (cyc_limit == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                // stop outranks both completion and a tick due this cycle
                if (stop) begin
                    state_nxt = S_IDLE;
                end else if (at_lim) begin
                    state_nxt = S_DONE;
                end else if (wrap) begin
                    do_wrap = 1'b1;
                    do_tick = tick_ok;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Round-robin search starting at ptr, wrapping modulo NREQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand_idx  = '0;
        for (int i = 0; i < NREQ; i++) begin
            int c;
            c = int'(ptr) + i;
            if (c >= NREQ) c = c - NREQ;
            cand_idx = PW'(c);
            if (!gnt_found && req[cand_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        gnt_oh          = '0;
        gnt_oh[gnt_idx] = gnt_found;
        ptr_nxt         = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre       <= '0;
            div_q     <= '0;
            lim_q     <= '0;
            cyc_count <= '0;
            ptr       <= '0;
            tick      <= 1'b0;
            gnt       <= '0;
        end else begin
            tick <= 1'b0;
            gnt  <= '0;
            if (do_start) begin
                div_q     <= div;
                lim_q     <= cyc_limit;
                pre       <= '0;
                cyc_count <= '0;
                ptr       <= '0;
            end else if (state == S_RUN) begin
                pre <= wrap ? '0 : pre + DIV_W'(1);
                if (do_tick) begin
                    tick      <= 1'b1;
                    cyc_count <= cyc_count + CYC_W'(1);
                    if (gnt_found) begin
                        gnt <= gnt_oh;
                        ptr <= ptr_nxt;
                    end
                end
            end
        end
    end

`ifdef TICK_SCHED_PHASE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       phase <= 1'b0;
        else if (do_start) phase <= 1'b0;
        else if (do_wrap)  phase <= ~phase;
    end
`endif

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_tick_sched.sv
// Directed bench for tick_sched with hand-computed tick, grant and completion timing.
// Covers the TICK_SCHED_PHASE_EN variant when that macro is defined.

module tb_tick_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stop;
    logic [7:0]  div;
    logic [15:0] cyc_limit;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic        tick;
    logic [15:0] cyc_count;
    logic        busy, done;
`ifdef TICK_SCHED_PHASE_EN
    logic        phase;
`endif

    int n_chk = 0;
    int n_bad = 0;

    tick_sched #(.NREQ(4), .DIV_W(8), .CYC_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .div       (div),
        .cyc_limit (cyc_limit),
        .req       (req),
        .gnt       (gnt),
        .tick      (tick),
        .cyc_count (cyc_count),
        .busy      (busy),
`ifdef TICK_SCHED_PHASE_EN
        .done      (done),
        .phase     (phase)
`else
        .done      (done)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] exp_gnt2 [3];
    logic [3:0] exp_gnt3 [5];

    initial begin
        exp_gnt2 = '{4'b0001, 4'b0010, 4'b0100};
        exp_gnt3 = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0010};

        rst_n = 1'b0; start = 1'b0; stop = 1'b0;
        div = '0; cyc_limit = '0; req = '0;
        #12;
        check("rst_gnt", gnt, 0);
        check("rst_tick", tick, 0);
        check("rst_cnt", cyc_count, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;

        // div=0, 10 ticks, single requester
        div = 8'd0; cyc_limit = 16'd10; req = 4'b0001; start = 1'b1;
        step();
        start = 1'b0;
        check("t1_busy", busy, 1);
        check("t1_tick0", tick, 0);
        for (int k = 1; k <= 10; k++) begin
            step();
            check("t1_tick", tick, 1);
            check("t1_gnt", gnt, 4'b0001);
            check("t1_cnt", cyc_count, k);
        end
        step();
        check("t1_done", done, 1);
        check("t1_busy_end", busy, 0);
        check("t1_tick_end", tick, 0);
        check("t1_cnt_end", cyc_count, 10);
        step();
        check("t1_tick_after", tick, 0);

        // div=3, 3 ticks, all requesting
        div = 8'd3; cyc_limit = 16'd3; req = 4'b1111; start = 1'b1;
        step();
        start = 1'b0;
        check("t2_cnt0", cyc_count, 0);
        for (int c = 1; c <= 12; c++) begin
            step();
            if (c % 4 == 0) begin
                check("t2_tick", tick, 1);
                check("t2_gnt", gnt, exp_gnt2[c/4 - 1]);
            end else begin
                check("t2_notick", tick, 0);
            end
        end
        check("t2_done_late", done, 0);
        step();
        check("t2_done", done, 1);

        // div=1, requesters 1 and 3 only
        div = 8'd1; cyc_limit = 16'd5; req = 4'b1010; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (c % 2 == 0) begin
                check("t3_tick", tick, 1);
                check("t3_gnt", gnt, exp_gnt3[c/2 - 1]);
            end else begin
                check("t3_notick", tick, 0);
            end
        end
        step();
        check("t3_done", done, 1);
        check("t3_cnt", cyc_count, 5);

        // no requests: ticks still counted, no grant
        div = 8'd0; cyc_limit = 16'd2; req = 4'b0000; start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("t4_tick", tick, 1);
        check("t4_gnt", gnt, 0);
        check("t4_cnt", cyc_count, 1);
        step();
        step();
        check("t4_done", done, 1);
        check("t4_cnt_end", cyc_count, 2);

        // stop together with start at cyc_count=7
        div = 8'd0; cyc_limit = 16'd100; req = 4'b0001; start = 1'b1;
        step();
        start = 1'b0;
        repeat (7) step();
        check("t5_cnt7", cyc_count, 7);
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        check("t5_stop_tick", tick, 0);
        check("t5_stop_gnt", gnt, 0);
        check("t5_stop_cnt", cyc_count, 7);
        check("t5_stop_busy", busy, 0);
        check("t5_stop_done", done, 0);
        step();
        check("t5_idle_busy", busy, 0);
        check("t5_idle_tick", tick, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("t5_restart_busy", busy, 1);
        check("t5_restart_cnt", cyc_count, 0);
        repeat (4) step();
        check("t5_cnt4", cyc_count, 4);

        // asynchronous reset mid-run
        #2 rst_n = 1'b0;
        #1;
        check("t6_gnt", gnt, 0);
        check("t6_tick", tick, 0);
        check("t6_cnt", cyc_count, 0);
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        step();
        rst_n = 1'b1;
        step();
        check("t6_held", busy, 0);

        // zero-length run
        div = 8'd0; cyc_limit = 16'd0; req = 4'b0001; start = 1'b1;
        step();
        start = 1'b0;
        check("t7_done", done, 1);
        check("t7_busy", busy, 0);
        check("t7_cnt", cyc_count, 0);
        check("t7_tick", tick, 0);
        step();
        check("t7_tick_after", tick, 0);

`ifdef TICK_SCHED_PHASE_EN
        div = 8'd0; cyc_limit = 16'd4; req = 4'b0001; start = 1'b1;
        step();
        start = 1'b0;
        check("t8_phase0", phase, 0);
        for (int c = 1; c <= 7; c++) begin
            step();
            check("t8_phase", phase, c % 2);
            check("t8_tick", tick, c % 2);
            check("t8_done_early", done, 0);
        end
        step();
        check("t8_done", done, 1);
        check("t8_cnt", cyc_count, 4);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
